// File: rtl/led_mode_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_mode_sequencer_pkg
// Description : Shared mode encoding for the LED mode sequencer and a helper
//               that advances the mode ring MANUAL -> AUTO -> BLINK -> MANUAL.
// Revision    : 1.0 - initial release
// ============================================================================
package led_mode_sequencer_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_MANUAL = 2'd0;
    localparam mode_t MODE_AUTO   = 2'd1;
    localparam mode_t MODE_BLINK  = 2'd2;

    // The unused encoding 3 also advances to MANUAL so a corrupted mode
    // register always lands back on a legal value.
    function automatic mode_t mode_advance(input mode_t m);
        case (m)
            MODE_MANUAL: mode_advance = MODE_AUTO;
            MODE_AUTO:   mode_advance = MODE_BLINK;
            default:     mode_advance = MODE_MANUAL;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_mode_sequencer_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Synchronises one raw push-button, debounces it with a
//               saturating-stability counter and emits a one-cycle press
//               pulse on each accepted released->pressed transition.
// Ports       : clk   - system clock (rising edge)
//               rst   - synchronous active-high reset
//               btn   - raw asynchronous button level, high = pressed
//               press - single-cycle pulse on an accepted press
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    logic                  r_sync1;
    logic                  r_sync2;
    logic                  r_state;
    logic [DEBOUNCE_W-1:0] r_cnt;
    logic                  w_cnt_max;

    assign w_cnt_max = &r_cnt;

    // The pulse is taken in the same cycle the counter saturates, i.e. the
    // cycle before the stored state flips, so it can only be high once.
    assign press = ~r_state & w_cnt_max & r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_state) begin
                r_cnt <= '0;
            end else begin
                // Wraps back to zero on the same edge the state flips.
                r_cnt <= r_cnt + DEBOUNCE_W'(1);
                if (w_cnt_max) begin
                    r_state <= ~r_state;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : led_mode_sequencer
// Description : Four-LED sequencer for three push-buttons. Debounced presses
//               drive a MANUAL / AUTO / BLINK mode ring, a step direction and
//               a one-hot LED position; a tick divider paces AUTO stepping
//               and BLINK toggling.
// Ports       : clk      - system clock (rising edge)
//               rst      - synchronous active-high reset
//               btn_next - raw button: step position (MANUAL only)
//               btn_mode - raw button: advance mode
//               btn_dir  - raw button: toggle step direction
//               led      - LED drive
//               mode     - current mode (0 MANUAL, 1 AUTO, 2 BLINK)
//               pos      - current position index
//               dir      - step direction (0 up, 1 down)
// Revision    : 1.0 - initial release
// ============================================================================
module led_mode_sequencer #(
    parameter int DEBOUNCE_W = 16,
    parameter int TICK_DIV   = 25000000,
    parameter int TICK_W     = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_next,
    input  logic       btn_mode,
    input  logic       btn_dir,
    output logic [3:0] led,
    output logic [1:0] mode,
    output logic [1:0] pos,
    output logic       dir
);

    import led_mode_sequencer_pkg::*;

    localparam logic [TICK_W-1:0] c_tick_last = TICK_W'(TICK_DIV - 1);

    logic              w_press_next;
    logic              w_press_mode;
    logic              w_press_dir;

    mode_t             r_mode;
    logic [1:0]        r_pos;
    logic              r_dir;
    logic              r_blink_on;
    logic [TICK_W-1:0] r_tick_cnt;

    mode_t             w_mode_nxt;
    logic [1:0]        w_pos_nxt;
    logic              w_dir_nxt;
    logic              w_blink_nxt;
    logic [TICK_W-1:0] w_tick_nxt;
    logic              w_tick;
    logic [1:0]        w_pos_step;

    btn_debounce #(.DEBOUNCE_W(DEBOUNCE_W)) u_db_next (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_next),
        .press (w_press_next)
    );

    btn_debounce #(.DEBOUNCE_W(DEBOUNCE_W)) u_db_mode (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_mode),
        .press (w_press_mode)
    );

    btn_debounce #(.DEBOUNCE_W(DEBOUNCE_W)) u_db_dir (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_dir),
        .press (w_press_dir)
    );

    // Counter is held at zero in MANUAL, so tick can only fire in AUTO/BLINK.
    assign w_tick    = (r_tick_cnt == c_tick_last);
    // A same-cycle dir press takes effect on the step it coincides with.
    assign w_dir_nxt = r_dir ^ w_press_dir;
    assign w_pos_step = w_dir_nxt ? (r_pos - 2'd1) : (r_pos + 2'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode     <= MODE_MANUAL;
            r_pos      <= 2'd0;
            r_dir      <= 1'b0;
            r_blink_on <= 1'b1;
            r_tick_cnt <= '0;
        end else begin
            r_mode     <= w_mode_nxt;
            r_pos      <= w_pos_nxt;
            r_dir      <= w_dir_nxt;
            r_blink_on <= w_blink_nxt;
            r_tick_cnt <= w_tick_nxt;
        end
    end

    always_comb begin
        w_mode_nxt  = r_mode;
        w_pos_nxt   = r_pos;
        w_blink_nxt = r_blink_on;
        w_tick_nxt  = '0;

        case (r_mode)
            MODE_MANUAL: begin
                if (w_press_next) begin
                    w_pos_nxt = w_pos_step;
                end
            end
            MODE_AUTO: begin
                w_tick_nxt = w_tick ? '0 : (r_tick_cnt + TICK_W'(1));
                if (w_tick) begin
                    w_pos_nxt = w_pos_step;
                end
            end
            MODE_BLINK: begin
                w_tick_nxt = w_tick ? '0 : (r_tick_cnt + TICK_W'(1));
                if (w_tick) begin
                    w_blink_nxt = ~r_blink_on;
                end
            end
            default: begin
                w_mode_nxt  = MODE_MANUAL;
                w_blink_nxt = 1'b1;
            end
        endcase

        // A mode press overrides any step or toggle in the same cycle and
        // restarts the tick phase for the new mode.
        if (w_press_mode) begin
            w_mode_nxt  = mode_advance(r_mode);
            w_pos_nxt   = r_pos;
            w_blink_nxt = 1'b1;
            w_tick_nxt  = '0;
        end
    end

    always_comb begin
        led = 4'b0001 << r_pos;
        if (r_mode == MODE_BLINK) begin
            led = {4{r_blink_on}};
        end
    end

    assign mode = r_mode;
    assign pos  = r_pos;
    assign dir  = r_dir;

endmodule
`default_nettype wire

// File: tb/tb_led_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_mode_sequencer
// Description : Scoreboard bench for led_mode_sequencer (DEBOUNCE_W=4,
//               TICK_DIV=8). Stimulus queues time-stamped expected outputs;
//               a negedge monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_mode_sequencer;

    localparam int c_tick = 8;
    // Raise at a negedge with edge counter N: effect visible when counter N+18.
    localparam int c_lat  = 18;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_next;
    logic       btn_mode;
    logic       btn_dir;
    logic [3:0] led;
    logic [1:0] mode;
    logic [1:0] pos;
    logic       dir;

    int edge_cnt = 0;
    int checks   = 0;
    int errors   = 0;

    typedef struct {
        int         at;
        string      name;
        logic [3:0] led;
        logic [1:0] mode;
        logic [1:0] pos;
        logic       dir;
    } exp_t;

    exp_t exp_q[$];

    led_mode_sequencer #(
        .DEBOUNCE_W (4),
        .TICK_DIV   (8),
        .TICK_W     (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_next (btn_next),
        .btn_mode (btn_mode),
        .btn_dir  (btn_dir),
        .led      (led),
        .mode     (mode),
        .pos      (pos),
        .dir      (dir)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic void push(input int at, input string name, input logic [3:0] l,
                                 input logic [1:0] m, input logic [1:0] p, input logic d);
        exp_t e;
        int   i;
        e.at = at; e.name = name; e.led = l; e.mode = m; e.pos = p; e.dir = d;
        i = 0;
        while (i < exp_q.size() && exp_q[i].at <= at) i++;
        exp_q.insert(i, e);
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] p);
        logic [3:0] v;
        v = 4'b0001;
        return v << p;
    endfunction

    // Position in AUTO entered at counter value e with start position p0.
    function automatic logic [1:0] auto_pos(input logic [1:0] p0, input int e, input int t,
                                            input bit down);
        int k;
        k = (t >= e) ? (t - e) / c_tick : 0;
        return down ? (p0 - 2'(k)) : (p0 + 2'(k));
    endfunction

    // Monitor: compare every expectation whose time stamp has come due.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].at <= edge_cnt) begin
            e = exp_q.pop_front();
            checks++;
            if (e.at < edge_cnt) begin
                errors++;
                $display("FAIL %s: expectation for edge %0d checked late at %0d", e.name, e.at, edge_cnt);
            end else if (led !== e.led || mode !== e.mode || pos !== e.pos || dir !== e.dir) begin
                errors++;
                $display("FAIL %s @%0d: got led=%b mode=%0d pos=%0d dir=%0d, expected led=%b mode=%0d pos=%0d dir=%0d",
                         e.name, edge_cnt, led, mode, pos, dir, e.led, e.mode, e.pos, e.dir);
            end
        end
    end

    task automatic btn_down(input bit nx, input bit md, input bit dr, output int eff);
        @(negedge clk);
        if (nx) btn_next = 1'b1;
        if (md) btn_mode = 1'b1;
        if (dr) btn_dir  = 1'b1;
        eff = edge_cnt + c_lat;
    endtask

    task automatic btn_up();
        repeat (20) @(negedge clk);
        btn_next = 1'b0;
        btn_mode = 1'b0;
        btn_dir  = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        int         eff, t0, e_auto, e_blink, e4, e5, e6, tr, guard;
        logic [1:0] p, pf, p5;

        rst = 1'b1; btn_next = 1'b0; btn_mode = 1'b0; btn_dir = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        push(edge_cnt + 1, "reset", 4'b0001, 2'd0, 2'd0, 1'b0);

        // Debounce latency of the first press.
        btn_down(1, 0, 0, eff);
        push(eff - 1, "t1_pre_press", 4'b0001, 2'd0, 2'd0, 1'b0);
        push(eff,     "t1_next",      4'b0010, 2'd0, 2'd1, 1'b0);
        btn_up();

        // MANUAL stepping and wrap both ways.
        btn_down(1, 0, 0, eff); push(eff, "t2_pos2",      4'b0100, 2'd0, 2'd2, 1'b0); btn_up();
        btn_down(1, 0, 0, eff); push(eff, "t2_pos3",      4'b1000, 2'd0, 2'd3, 1'b0); btn_up();
        btn_down(1, 0, 0, eff); push(eff, "t2_wrap_up",   4'b0001, 2'd0, 2'd0, 1'b0); btn_up();
        btn_down(0, 0, 1, eff); push(eff, "t2_dir",       4'b0001, 2'd0, 2'd0, 1'b1); btn_up();
        btn_down(1, 0, 0, eff); push(eff, "t2_wrap_down", 4'b1000, 2'd0, 2'd3, 1'b1); btn_up();

        // Short glitch is rejected.
        @(negedge clk);
        btn_next = 1'b1;
        t0 = edge_cnt;
        push(t0 + 20, "t2_glitch_mid", 4'b1000, 2'd0, 2'd3, 1'b1);
        push(t0 + 40, "t2_glitch_end", 4'b1000, 2'd0, 2'd3, 1'b1);
        repeat (10) @(negedge clk);
        btn_next = 1'b0;
        repeat (40) @(negedge clk);

        btn_down(0, 0, 1, eff); push(eff, "t3_dir_up", 4'b1000, 2'd0, 2'd3, 1'b0); btn_up();

        // AUTO: first step TICK_DIV cycles after entry, then every TICK_DIV.
        btn_down(0, 1, 0, e_auto);
        push(e_auto - 1,  "t3_pre_mode",  4'b1000, 2'd0, 2'd3, 1'b0);
        push(e_auto,      "t3_auto",      4'b1000, 2'd1, 2'd3, 1'b0);
        push(e_auto + 7,  "t3_no_step_7", 4'b1000, 2'd1, 2'd3, 1'b0);
        push(e_auto + 8,  "t3_step_8",    4'b0001, 2'd1, 2'd0, 1'b0);
        push(e_auto + 16, "t3_step_16",   4'b0010, 2'd1, 2'd1, 1'b0);
        push(e_auto + 24, "t3_step_24",   4'b0100, 2'd1, 2'd2, 1'b0);
        btn_up();

        btn_down(1, 0, 0, eff);
        p = auto_pos(2'd3, e_auto, eff, 1'b0);
        push(eff, "t3_next_ignored", onehot(p), 2'd1, p, 1'b0);
        btn_up();

        // BLINK: all on at entry, toggles every TICK_DIV, position frozen.
        btn_down(0, 1, 0, e_blink);
        pf = auto_pos(2'd3, e_auto, e_blink - 1, 1'b0);
        push(e_blink,      "t4_blink_entry", 4'b1111, 2'd2, pf, 1'b0);
        push(e_blink + 7,  "t4_blink_on_7",  4'b1111, 2'd2, pf, 1'b0);
        push(e_blink + 8,  "t4_blink_off",   4'b0000, 2'd2, pf, 1'b0);
        push(e_blink + 16, "t4_blink_on",    4'b1111, 2'd2, pf, 1'b0);
        btn_up();

        btn_down(0, 1, 0, eff); push(eff, "t4_manual", onehot(pf), 2'd0, pf, 1'b0); btn_up();

        // Mode press coincident with next press: next is dropped.
        btn_down(1, 1, 0, e4);
        push(e4, "t5_mode_beats_next", onehot(pf), 2'd1, pf, 1'b0);
        btn_up();

        // Mode press coincident with an AUTO tick: step is dropped.
        while (((edge_cnt + 1 + c_lat - e4) % c_tick) != 0) @(negedge clk);
        btn_down(0, 1, 0, e5);
        p5 = auto_pos(pf, e4, e5 - 1, 1'b0);
        push(e5 - 1, "t5_pre_tick",     onehot(p5), 2'd1, p5, 1'b0);
        push(e5,     "t5_tick_dropped", 4'b1111,    2'd2, p5, 1'b0);
        push(e5 + 7, "t5_restart_on",   4'b1111,    2'd2, p5, 1'b0);
        push(e5 + 8, "t5_restart_off",  4'b0000,    2'd2, p5, 1'b0);
        btn_up();

        btn_down(0, 1, 0, eff); push(eff, "t6_manual",   onehot(p5), 2'd0, p5, 1'b0); btn_up();
        btn_down(0, 0, 1, eff); push(eff, "t6_dir_down", onehot(p5), 2'd0, p5, 1'b1); btn_up();
        btn_down(0, 1, 0, e6);  push(e6,  "t6_auto",     onehot(p5), 2'd1, p5, 1'b1); btn_up();

        // Reset in AUTO at pos=2, dir=1, tick count 5, with btn_next held.
        tr = edge_cnt + 2;
        while (!(auto_pos(p5, e6, tr, 1'b1) == 2'd2 && ((tr - e6) % c_tick) == 5)) tr++;
        push(tr,      "t6_pre_reset",     4'b0100, 2'd1, 2'd2, 1'b1);
        push(tr + 1,  "t6_reset",         4'b0001, 2'd0, 2'd0, 1'b0);
        push(tr + 18, "t6_held_pre",      4'b0001, 2'd0, 2'd0, 1'b0);
        push(tr + 19, "t6_held_press",    4'b0010, 2'd0, 2'd1, 1'b0);
        push(tr + 70, "t6_single_press",  4'b0010, 2'd0, 2'd1, 1'b0);
        while (edge_cnt < tr) @(negedge clk);
        rst      = 1'b1;
        btn_next = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        btn_next = 1'b0;

        guard = 0;
        while (exp_q.size() > 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
